// File: rtl/gesture_decoder_debounced_if.sv
// Sensor-to-gesture bus: raw sensor vector in, decoded gesture and status out.
interface gesture_decoder_debounced_if #(
    parameter int unsigned SENSOR_W = 4,
    parameter int unsigned CODE_W   = 4,
    parameter int unsigned CNT_W    = 8
) ();

    logic [SENSOR_W-1:0] sensor_in;
    logic [CODE_W-1:0]   gesture;
    logic                gesture_valid;
    logic                gesture_active;
    logic [CNT_W-1:0]    event_count;

    // Front-end / consumer side
    modport master (
        output sensor_in,
        input  gesture,
        input  gesture_valid,
        input  gesture_active,
        input  event_count
    );

    // Decoder side
    modport slave (
        input  sensor_in,
        output gesture,
        output gesture_valid,
        output gesture_active,
        output event_count
    );

endinterface

// File: rtl/gesture_decoder_debounced.sv
// Debounced gesture decoder: synchronises a raw sensor vector, qualifies a stable
// pattern, maps it to a gesture code, holds it after release and counts events.
module gesture_decoder_debounced #(
    parameter int unsigned SENSOR_W = 4,
    parameter int unsigned CODE_W = 4,
    parameter logic [(2**SENSOR_W)*CODE_W-1:0] GESTURE_MAP = 64'h97F4E31AD65B8C20,
    parameter int unsigned STABLE_CYCLES = 8,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    gesture_decoder_debounced_if.slave bus
);

    localparam int unsigned StabW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
    localparam logic [StabW-1:0] StableMax = StabW'(STABLE_CYCLES);
    localparam logic [HoldW-1:0] HoldInit = HoldW'(HOLD_CYCLES);

    typedef enum logic [1:0] {StIdle, StQualify, StLatched, StRelease} state_e;

    state_e              state_q, state_d;
    logic [SENSOR_W-1:0] sync1_q, sync1_d;
    logic [SENSOR_W-1:0] s_q, s_d;
    logic [SENSOR_W-1:0] cand_q, cand_d;
    logic [StabW-1:0]    stab_q, stab_d;
    logic [HoldW-1:0]    hold_q, hold_d;
    logic                from_hold_q, from_hold_d;
    logic [CODE_W-1:0]   gesture_q, gesture_d;
    logic                valid_q, valid_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CODE_W-1:0]   code_s;
    logic                s_null;

    assign code_s = GESTURE_MAP[int'(s_q)*CODE_W +: CODE_W];
    // Patterns mapping to code 0 behave exactly like an all-zero input
    assign s_null = (code_s == '0);

    // Next-state, qualification, hold timer and event counter
    always_comb begin
        state_d     = state_q;
        sync1_d     = bus.sensor_in;
        s_d         = sync1_q;
        cand_d      = cand_q;
        stab_d      = stab_q;
        hold_d      = hold_q;
        from_hold_d = from_hold_q;
        gesture_d   = gesture_q;
        valid_d     = 1'b0;
        count_d     = count_q;

        unique case (state_q)
            StIdle: begin
                gesture_d = '0;
                if (!s_null) begin
                    cand_d      = s_q;
                    stab_d      = StabW'(1);
                    from_hold_d = 1'b0;
                    state_d     = StQualify;
                end
            end
            StQualify: begin
                // A pending hold keeps running, but never expires mid-qualify
                if (from_hold_q && (hold_q > HoldW'(1))) begin
                    hold_d = hold_q - 1'b1;
                end
                if (s_null) begin
                    state_d = from_hold_q ? StRelease : StIdle;
                end else if (s_q == cand_q) begin
                    if (stab_q >= StableMax) begin
                        gesture_d = code_s;
                        valid_d   = 1'b1;
                        count_d   = (&count_q) ? count_q : count_q + 1'b1;
                        state_d   = StLatched;
                    end else begin
                        stab_d = stab_q + 1'b1;
                    end
                end else begin
                    cand_d = s_q;
                    stab_d = StabW'(1);
                end
            end
            StLatched: begin
                if (s_null) begin
                    hold_d  = HoldInit;
                    state_d = StRelease;
                end else if (s_q != cand_q) begin
                    cand_d      = s_q;
                    stab_d      = StabW'(1);
                    from_hold_d = 1'b1;
                    hold_d      = HoldInit;
                    state_d     = StQualify;
                end
            end
            StRelease: begin
                if (!s_null) begin
                    cand_d      = s_q;
                    stab_d      = StabW'(1);
                    from_hold_d = 1'b1;
                    if (hold_q > HoldW'(1)) begin
                        hold_d = hold_q - 1'b1;
                    end
                    state_d = StQualify;
                end else if (hold_q <= HoldW'(1)) begin
                    hold_d    = '0;
                    gesture_d = '0;
                    state_d   = StIdle;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sync1_q     <= '0;
            s_q         <= '0;
            cand_q      <= '0;
            stab_q      <= '0;
            hold_q      <= '0;
            from_hold_q <= 1'b0;
            gesture_q   <= '0;
            valid_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            s_q         <= s_d;
            cand_q      <= cand_d;
            stab_q      <= stab_d;
            hold_q      <= hold_d;
            from_hold_q <= from_hold_d;
            gesture_q   <= gesture_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
        end
    end

    assign bus.gesture        = gesture_q;
    assign bus.gesture_valid  = valid_q;
    assign bus.gesture_active = (state_q == StLatched) || (state_q == StRelease);
    assign bus.event_count    = count_q;

endmodule
